// File: rtl/stream_pkg.sv
// Shared definitions for valid/ready stream stages.
package stream_pkg;

  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  typedef struct packed {
    logic valid;
    logic ready;
  } hs_t;

endpackage

// File: rtl/stream_fifo_mem.sv
// Register-array storage for stream_fifo: synchronous write, asynchronous indexed read.
module fifo_mem #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/stream_fifo.sv
// First-word-fall-through FIFO with valid/ready on both sides, occupancy and almost-full status.
module stream_fifo
  import stream_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned AFULL_THRESH = DEPTH - 1
) (
  input  logic                         Clk_CI,
  input  logic                         Rst_RI,
  input  logic                         Flush_SI,
  input  logic [DATA_WIDTH-1:0]        InData_DI,
  input  logic                         InValid_SI,
  output logic                         InReady_SO,
  output logic [DATA_WIDTH-1:0]        OutData_DO,
  output logic                         OutValid_SO,
  input  logic                         OutReady_SI,
  output logic [$clog2(DEPTH):0]       Count_DO,
  output logic                         AlmostFull_SO
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = ptr_width(DEPTH);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("stream_fifo: DEPTH must be a power of two and >= 2");
  end
  if ((AFULL_THRESH < 1) || (AFULL_THRESH > DEPTH)) begin : g_bad_thresh
    $error("stream_fifo: AFULL_THRESH must lie in 1..DEPTH");
  end

  logic [PW-1:0]         wr_ptr, rd_ptr, count;
  logic                  empty, full, push, pop;
  logic [DATA_WIDTH-1:0] head;
  hs_t                   in_hs, out_hs;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

  // Ready looks only at full and reset, so a pop never frees a slot in the same cycle.
  assign in_hs  = '{valid: InValid_SI, ready: !full && !Rst_RI};
  assign out_hs = '{valid: !empty,     ready: OutReady_SI};
  assign push   = in_hs.valid && in_hs.ready;
  assign pop    = out_hs.valid && out_hs.ready;

  always_ff @(posedge Clk_CI) begin
    if (Rst_RI || Flush_SI) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + PW'(1);
        2'b01:   count <= count - PW'(1);
        default: count <= count;
      endcase
    end
  end

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (AW)
  ) u_mem (
    .clk   (Clk_CI),
    .we    (push && !Flush_SI),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (InData_DI),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (head)
  );

  assign InReady_SO    = in_hs.ready;
  assign OutValid_SO   = out_hs.valid;
  assign OutData_DO    = out_hs.valid ? head : '0;
  assign Count_DO      = count;
  assign AlmostFull_SO = (count >= PW'(AFULL_THRESH));

endmodule

// File: tb/tb_stream_fifo.sv
// Directed bench for stream_fifo: stimulus pushes expected words, a negedge monitor checks pops.
module tb_stream_fifo;

  logic       clk;
  logic       rst;
  logic       flush;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] count;
  logic       afull;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [7:0]  exp_q[$];

  stream_fifo #(
    .DATA_WIDTH   (8),
    .DEPTH        (4),
    .AFULL_THRESH (3)
  ) dut (
    .Clk_CI        (clk),
    .Rst_RI        (rst),
    .Flush_SI      (flush),
    .InData_DI     (in_data),
    .InValid_SI    (in_valid),
    .InReady_SO    (in_ready),
    .OutData_DO    (out_data),
    .OutValid_SO   (out_valid),
    .OutReady_SI   (out_ready),
    .Count_DO      (count),
    .AlmostFull_SO (afull)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: a pop happens on the next rising edge whenever valid&ready is seen here.
  logic       prev_valid = 1'b0;
  logic       prev_pop   = 1'b0;
  logic       prev_clr   = 1'b0;
  logic [7:0] prev_data  = '0;
  initial begin
    forever begin
      @(negedge clk);
      if (prev_valid && !prev_pop && !prev_clr) begin
        check("hold_valid", {31'd0, out_valid}, 32'd1);
        check("hold_data", {24'd0, out_data}, {24'd0, prev_data});
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL pop_unexpected: got %0h expected none", out_data);
        end else begin
          check("pop_data", {24'd0, out_data}, {24'd0, exp_q.pop_front()});
        end
      end
      prev_valid = out_valid;
      prev_pop   = out_valid && out_ready;
      prev_clr   = flush || rst;
      prev_data  = out_data;
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (3) step();
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", {24'd0, out_data}, 32'd0);
    check("rst_count", {29'd0, count}, 32'd0);
    check("rst_afull", {31'd0, afull}, 32'd0);
    rst = 1'b0;
    step();
    check("rel_in_ready", {31'd0, in_ready}, 32'd1);
    check("rel_out_valid", {31'd0, out_valid}, 32'd0);
    check("rel_count", {29'd0, count}, 32'd0);

    // single word, fall-through after one edge
    in_valid = 1'b1; in_data = 8'h11; exp_q.push_back(8'h11);
    step();
    in_valid = 1'b0;
    check("first_valid", {31'd0, out_valid}, 32'd1);
    check("first_data", {24'd0, out_data}, 32'h11);
    check("first_count", {29'd0, count}, 32'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("first_drained", {29'd0, count}, 32'd0);

    // fill to DEPTH
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 8'hA0 + 8'(i); exp_q.push_back(in_data);
      step();
      check("fill_count", {29'd0, count}, i + 1);
      check("fill_afull", {31'd0, afull}, (i >= 2) ? 32'd1 : 32'd0);
    end
    check("full_in_ready", {31'd0, in_ready}, 32'd0);
    in_data = 8'hFF; out_ready = 1'b1;
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    check("full_pop_count", {29'd0, count}, 32'd3);
    check("full_pop_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    repeat (3) step();
    out_ready = 1'b0;
    check("fill_drained", {29'd0, count}, 32'd0);

    // streaming
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_data = 8'(i); exp_q.push_back(in_data);
      step();
      check("stream_count", {29'd0, count}, 32'd1);
    end
    in_valid = 1'b0;
    step();
    out_ready = 1'b0;
    check("stream_drained", {29'd0, count}, 32'd0);

    // wrap-around rounds
    for (int r = 0; r < 10; r++) begin
      for (int k = 0; k < 3; k++) begin
        in_valid = 1'b1; in_data = 8'(r * 16 + k); exp_q.push_back(in_data);
        step();
      end
      in_valid = 1'b0;
      check("wrap_fill", {29'd0, count}, 32'd3);
      out_ready = 1'b1;
      repeat (3) step();
      out_ready = 1'b0;
      check("wrap_drain", {29'd0, count}, 32'd0);
    end

    // flush with a concurrent push
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1; in_data = 8'h31 + 8'(k); exp_q.push_back(in_data);
      step();
    end
    check("preflush_count", {29'd0, count}, 32'd2);
    flush = 1'b1; in_valid = 1'b1; in_data = 8'h55;
    #1;
    check("flush_in_ready", {31'd0, in_ready}, 32'd1);
    step();
    flush = 1'b0; in_valid = 1'b0;
    exp_q.delete();
    check("flush_count", {29'd0, count}, 32'd0);
    check("flush_valid", {31'd0, out_valid}, 32'd0);
    in_valid = 1'b1; in_data = 8'h66; exp_q.push_back(8'h66);
    step();
    in_valid = 1'b0;
    check("postflush_data", {24'd0, out_data}, 32'h66);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // reset mid-burst
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_data = 8'h71 + 8'(k); exp_q.push_back(in_data);
      step();
    end
    in_valid = 1'b0;
    check("prerst_count", {29'd0, count}, 32'd3);
    rst = 1'b1;
    exp_q.delete();
    for (int c = 0; c < 2; c++) begin
      step();
      check("midrst_in_ready", {31'd0, in_ready}, 32'd0);
      check("midrst_valid", {31'd0, out_valid}, 32'd0);
      check("midrst_count", {29'd0, count}, 32'd0);
    end
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1; in_data = 8'h81 + 8'(k); exp_q.push_back(in_data);
      step();
    end
    in_valid = 1'b0;
    check("postrst_data", {24'd0, out_data}, 32'h81);
    out_ready = 1'b1;
    repeat (2) step();
    out_ready = 1'b0;
    check("postrst_count", {29'd0, count}, 32'd0);

    repeat (2) step();
    check("queue_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
